// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } state_e;

endpackage

// File: rtl/addsub_cla.sv
// Combinational N-bit add/subtract built from 4-bit carry-lookahead groups.
module addsub_cla #(
    parameter int unsigned N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    localparam int unsigned NG = (N + 3) / 4;
    localparam int unsigned NP = NG * 4;

    logic [NP-1:0] a_ext, b_ext, g, p, c, s_ext;
    logic [NG:0]   carry;

    // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
    assign a_ext = NP'(a);
    assign b_ext = NP'(b ^ {N{sub}});
    assign g     = a_ext & b_ext;
    assign p     = a_ext ^ b_ext;

    always_comb begin
        c        = '0;
        carry    = '0;
        carry[0] = sub;
        for (int k = 0; k < int'(NG); k++) begin
            c[4*k]     = carry[k];
            c[4*k+1]   = g[4*k] | (p[4*k] & carry[k]);
            c[4*k+2]   = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry[k]);
            c[4*k+3]   = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & carry[k]);
            carry[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                       | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                       | ((&p[4*k +: 4]) & carry[k]);
        end
    end

    assign s_ext = p ^ c;
    assign sum   = s_ext[N-1:0];

    if (NP > N) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^s_ext[NP-1:N];
    end

    logic unused_cout;
    assign unused_cout = carry[NG];

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
module div16_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH:0]   p_q, p_d, addsub_a, addsub_sum;
    logic [WIDTH-1:0] a_q, a_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    // ITER feeds the shifted {P,A}; FIX feeds P itself for the final correction.
    assign addsub_a = (state_q == StIter) ? {p_q[WIDTH-1:0], a_q[WIDTH-1]} : p_q;

    addsub_cla #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a  (addsub_a),
        .b  ({1'b0, d_q}),
        .sub(~p_q[WIDTH]),
        .sum(addsub_sum)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        a_d     = a_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        a_d     = dividend;
                        p_d     = '0;
                        count_d = '0;
                        busy_d  = 1'b1;
                        state_d = StIter;
                    end else begin
                        quot_d = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StIter: begin
                p_d     = addsub_sum;
                a_d     = {a_q[WIDTH-2:0], ~addsub_sum[WIDTH]};
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                rem_d   = p_q[WIDTH] ? addsub_sum[WIDTH-1:0] : p_q[WIDTH-1:0];
                quot_d  = a_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            p_q     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            a_q     <= a_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: vector table plus scoreboard of expected results.
module tb_div16_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    div16_seq #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            check("busy_low_at_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with q=0x%0h r=0x%0h, expected none",
                         quotient, remainder);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs, input logic push,
                         input logic [15:0] q, input logic [15:0] r, input logic dbz);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        if (push) sb.push_back('{q: q, r: r, dbz: dbz});
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Returns cycles (negedges) until done is seen, and how many of them had busy high.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!done && n < 60);
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    vec_t vecs[11];

    initial begin
        int n, nb, d0;
        vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0};
        vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0};
        vecs[2]  = '{16'h0005,  16'h0009,   16'h0000,   16'h0005,   1'b0};
        vecs[3]  = '{16'h8000,  16'hFFFF,   16'h0000,   16'h8000,   1'b0};
        vecs[4]  = '{16'hFFFF,  16'h8000,   16'h0001,   16'h7FFF,   1'b0};
        vecs[5]  = '{16'h04D2,  16'h0000,   16'hFFFF,   16'h04D2,   1'b1};
        vecs[6]  = '{16'd10,    16'd3,      16'd3,      16'd1,      1'b0};
        vecs[7]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0};
        vecs[8]  = '{16'd12345, 16'd12345,  16'd1,      16'd0,      1'b0};
        vecs[9]  = '{16'd1000,  16'd33,     16'd30,     16'd10,     1'b0};
        vecs[10] = '{16'd65535, 16'd256,    16'd255,    16'd255,    1'b0};

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each next start is raised in the done cycle of the previous one.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].dvd, vecs[i].dvs, 1'b1, vecs[i].q, vecs[i].r, vecs[i].dbz);
            wait_done(n, nb);
            check("latency", 32'(n), (vecs[i].dvs == 0) ? 32'd1 : 32'(W + 2));
            check("busy_cycles", 32'(nb), (vecs[i].dvs == 0) ? 32'd0 : 32'(W + 1));
        end

        // Starts at E5 and E9 with other operands must be ignored.
        @(posedge clk);
        #1;
        d0 = done_cnt;
        issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; dividend = 16'd200; divisor = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        check("ignored_start_latency", 32'(n), 32'd9);
        repeat (25) @(negedge clk);
        check("single_done_pulse", 32'(done_cnt - d0), 32'd1);

        // Back-to-back: second start in the done cycle of the first.
        issue(16'd1000, 16'd33, 1'b1, 16'd30, 16'd10, 1'b0);
        wait_done(n, nb);
        issue(16'd65535, 16'd256, 1'b1, 16'd255, 16'd255, 1'b0);
        wait_done(n, nb);
        check("b2b_latency", 32'(n), 32'(W + 2));

        // Asynchronous reset at E8 of a running divide: outputs clear, no done.
        @(posedge clk);
        #1;
        issue(16'd100, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        @(posedge clk);
        #1;
        issue(16'd10, 16'd3, 1'b1, 16'd3, 16'd1, 1'b0);
        wait_done(n, nb);
        check("post_reset_latency", 32'(n), 32'(W + 2));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
